// File: rtl/sequential_divider_16bit.sv
// 16-bit restoring shift-subtract divider, one quotient bit per clock.
// Define SEQ_DIVIDER_16BIT_SIGNED_EN to enable two's-complement division via signed_op.
module sequential_divider_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  input  logic        signed_op,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is accepted on a rising edge while state is IDLE or DONE;
  // busy is high for every CALC cycle; done is a one-cycle pulse in DONE with
  // quotient/remainder/flags valid, and those outputs hold until the next acceptance.

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] quo_q, quo_d;        // dividend bits shifting out, quotient bits shifting in
  logic [15:0] rem_q, rem_d;        // running partial remainder
  logic [15:0] dsr_q, dsr_d;        // divisor magnitude
  logic        fast_q, fast_d;      // result preloaded, finish after one CALC cycle
  logic        zero_q, zero_d;
  logic        ovfc_q, ovfc_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic        sgn;
  logic        accept;
  logic [15:0] a_mag, b_mag;
  logic        ovf_cond;
  logic [16:0] pr;
  logic [17:0] diff;
  logic        borrow;
  logic [15:0] step_rem, step_quo;

`ifdef SEQ_DIVIDER_16BIT_SIGNED_EN
  assign sgn = signed_op;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn = 1'b0;
`endif

  assign accept   = start && (state_q != CALC);
  assign a_mag    = (sgn && dividend[15]) ? (~dividend + 16'd1) : dividend;
  assign b_mag    = (sgn && divisor[15])  ? (~divisor + 16'd1)  : divisor;
  assign ovf_cond = sgn && (dividend == 16'h8000) && (divisor == 16'hFFFF);

  // 17-bit partial remainder; bit 17 of the difference is the borrow (carry-out 0)
  assign pr       = {rem_q, quo_q[15]};
  assign diff     = {1'b0, pr} - {2'b00, dsr_q};
  assign borrow   = diff[17];
  assign step_rem = borrow ? pr[15:0] : diff[15:0];
  assign step_quo = {quo_q[14:0], ~borrow};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    fast_d      = fast_q;
    zero_d      = zero_q;
    ovfc_d      = ovfc_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      CALC: begin
        if (fast_q) begin
          state_d     = DONE;
          quotient_d  = quo_q;
          remainder_d = rem_q;
          dbz_d       = zero_q;
          ovf_d       = ovfc_q;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d     = DONE;
            quotient_d  = qneg_q ? (~step_quo + 16'd1) : step_quo;
            remainder_d = rneg_q ? (~step_rem + 16'd1) : step_rem;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          state_d = CALC;
          cnt_d   = 4'd0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          dsr_d   = b_mag;
          fast_d  = 1'b0;
          zero_d  = 1'b0;
          ovfc_d  = 1'b0;
          qneg_d  = sgn && (dividend[15] ^ divisor[15]);
          rneg_d  = sgn && dividend[15];
          quo_d   = a_mag;
          rem_d   = 16'd0;
          // Special cases preload their final result and skip the shift loop
          if (divisor == 16'd0) begin
            fast_d = 1'b0 | 1'b1;
            zero_d = 1'b1;
            quo_d  = 16'hFFFF;
            rem_d  = dividend;
          end else if (ovf_cond) begin
            fast_d = 1'b1;
            ovfc_d = 1'b1;
            quo_d  = 16'h8000;
            rem_d  = 16'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      quo_q       <= 16'd0;
      rem_q       <= 16'd0;
      dsr_q       <= 16'd0;
      fast_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovfc_q      <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      fast_q      <= fast_d;
      zero_q      <= zero_d;
      ovfc_q      <= ovfc_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
`ifdef SEQ_DIVIDER_16BIT_SIGNED_EN
  assign overflow    = ovf_q;
`else
  assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider_16bit.sv
// Scoreboard bench for sequential_divider_16bit with hand-computed directed vectors.
// Signed vectors apply when SEQ_DIVIDER_16BIT_SIGNED_EN is defined.
module tb_sequential_divider_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        signed_op;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  localparam int W = 66;  // {quotient, remainder, dbz, ovf, done_cycle[31:0]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  sequential_divider_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(mon_e[65:50]));
        chk("remainder", 32'(remainder), 32'(mon_e[49:34]));
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e[33]));
        chk("overflow", 32'(overflow), 32'(mon_e[32]));
        chk("done_cycle", 32'(cyc), mon_e[31:0]);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // driver: present operands for one edge, optionally record the expected result
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] eq, input logic [15:0] er, input logic ed,
                       input logic eo, input int lat, input bit push);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    if (push) exp_q.push_back({eq, er, ed, eo, 32'(cyc + 1 + lat)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [15:0] eq, input logic [15:0] er, input logic ed,
                     input logic eo, input int lat);
    issue(a, b, s, eq, er, ed, eo, lat, 1'b1);
    repeat (lat + 1) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 100 / 7 with busy profile over the 16 CALC cycles
    issue(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0, 16, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("busy_calc", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    run(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16);
    run(16'h0005, 16'h0000, 1'b0, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 1);
    run(16'hABCD, 16'h0100, 1'b0, 16'h00AB, 16'h00CD, 1'b0, 1'b0, 16);
    run(16'd3,    16'd10,   1'b0, 16'd0,    16'd3,    1'b0, 1'b0, 16);
    run(16'd0,    16'd5,    1'b0, 16'd0,    16'd0,    1'b0, 1'b0, 16);
    run(16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 1'b0, 1'b0, 16);
`ifdef SEQ_DIVIDER_16BIT_SIGNED_EN
    run(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16);
    run(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1);
    run(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 16);
    run(16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 16);
    run(16'hFFF9, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 1'b0, 1);
`else
    run(16'hFFF9, 16'h0002, 1'b1, 16'h7FFC, 16'h0001, 1'b0, 1'b0, 16);
    run(16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b0, 16);
`endif

    // start during CALC with other operands must be ignored
    issue(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0, 1'b0, 16, 1'b1);
    repeat (5) @(negedge clk);
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);

    // reset at CALC cycle 8 abandons the operation
    issue(16'd1000, 16'd7, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0, 1'b0, 16);

    // start held through DONE: back-to-back acceptance
    @(negedge clk);
    dividend = 16'd5; divisor = 16'd0; signed_op = 1'b0; start = 1'b1;
    exp_q.push_back({16'hFFFF, 16'h0005, 1'b1, 1'b0, 32'(cyc + 2)});
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    dividend = 16'd200; divisor = 16'd9;
    exp_q.push_back({16'd22, 16'd2, 1'b0, 1'b0, 32'(cyc + 1 + 16)});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_dbz_cleared", 32'(div_by_zero), 32'd0);
    chk("b2b_quotient_hold", 32'(quotient), 32'hFFFF);
    repeat (20) @(negedge clk);

    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
